// File: rtl/serial_adder.sv
// Bit-serial adder/subtractor: one full-adder stage with a registered carry,
// LSB first, W cycles per operation, with a busy/done handshake.
module serial_adder #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         sub,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] sum,
  output logic         cout
);

  localparam int CW = (W > 1) ? $clog2(W) : 1;

  typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

  state_t         state_reg, state_next;
  logic [W-1:0]   a_reg, a_next;
  logic [W-1:0]   b_reg, b_next;
  logic [W-1:0]   acc_reg, acc_next;
  logic [W-1:0]   sum_reg, sum_next;
  logic           c_reg, c_next;
  logic           cout_reg, cout_next;
  logic [CW-1:0]  cnt_reg, cnt_next;

  logic           s_bit;
  logic           c_bit;
  logic           last_bit;
  logic [W-1:0]   acc_shift;

  assign s_bit    = a_reg[0] ^ b_reg[0] ^ c_reg;
  assign c_bit    = (a_reg[0] & b_reg[0]) | (c_reg & (a_reg[0] ^ b_reg[0]));
  assign last_bit = (cnt_reg == CW'(W - 1));

  // New sum bit enters at the MSB so after W shifts bit 0 lands at the LSB.
  generate
    if (W == 1) begin : g_one
      assign acc_shift = s_bit;
    end else begin : g_multi
      assign acc_shift = {s_bit, acc_reg[W-1:1]};
    end
  endgenerate

  always_comb begin
    state_next = state_reg;
    a_next     = a_reg;
    b_next     = b_reg;
    acc_next   = acc_reg;
    sum_next   = sum_reg;
    c_next     = c_reg;
    cout_next  = cout_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      IDLE: begin
        if (start) begin
          a_next     = a;
          b_next     = sub ? ~b : b;
          c_next     = sub ? 1'b1 : cin;
          cnt_next   = '0;
          acc_next   = '0;
          state_next = RUN;
        end
      end
      RUN: begin
        a_next   = a_reg >> 1;
        b_next   = b_reg >> 1;
        c_next   = c_bit;
        acc_next = acc_shift;
        cnt_next = cnt_reg + CW'(1);
        if (last_bit) begin
          sum_next   = acc_shift;
          cout_next  = c_bit;
          state_next = FIN;
        end
      end
      FIN: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      a_reg     <= '0;
      b_reg     <= '0;
      acc_reg   <= '0;
      sum_reg   <= '0;
      c_reg     <= 1'b0;
      cout_reg  <= 1'b0;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      a_reg     <= a_next;
      b_reg     <= b_next;
      acc_reg   <= acc_next;
      sum_reg   <= sum_next;
      c_reg     <= c_next;
      cout_reg  <= cout_next;
      cnt_reg   <= cnt_next;
    end
  end

  assign busy = (state_reg == RUN);
  assign done = (state_reg == FIN);
  assign sum  = sum_reg;
  assign cout = cout_reg;

endmodule

// File: tb/tb_serial_adder.sv
// Directed + scoreboard bench for serial_adder at W=8 and W=1.
module tb_serial_adder;

  logic       clk = 1'b0;
  logic       rst;
  logic       start8, sub8, cin8;
  logic [7:0] a8, b8;
  logic       busy8, done8, cout8;
  logic [7:0] sum8;
  logic       start1, sub1, cin1;
  logic [0:0] a1, b1;
  logic       busy1, done1, cout1;
  logic [0:0] sum1;

  int n_assert = 0;
  int n_fail   = 0;
  logic [8:0] exp_q[$];
  logic [1:0] exp1_q[$];

  always #5 clk = ~clk;

  serial_adder #(.W(8)) u8 (
    .clk(clk), .rst(rst), .start(start8), .sub(sub8), .a(a8), .b(b8),
    .cin(cin8), .busy(busy8), .done(done8), .sum(sum8), .cout(cout8)
  );

  serial_adder #(.W(1)) u1 (
    .clk(clk), .rst(rst), .start(start1), .sub(sub1), .a(a1), .b(b1),
    .cin(cin1), .busy(busy1), .done(done1), .sum(sum1), .cout(cout1)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [8:0] model8(input logic [7:0] x, input logic [7:0] y,
                                        input logic c, input logic s);
    if (s) return {1'b0, x} + {1'b0, ~y} + 9'd1;
    return {1'b0, x} + {1'b0, y} + {8'd0, c};
  endfunction

  // Called at a negedge; returns at the negedge after the FIN->IDLE edge.
  task automatic do8(input logic [7:0] ta, input logic [7:0] tb_, input logic tcin,
                     input logic tsub, input logic [8:0] exp, input string tag);
    int busy_n = 0;
    bit seen = 0;
    bit overlap = 0;
    logic [8:0] want;
    a8 = ta; b8 = tb_; cin8 = tcin; sub8 = tsub; start8 = 1'b1;
    exp_q.push_back(exp);
    @(negedge clk);
    start8 = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      if (busy8 && done8) overlap = 1;
      if (busy8) busy_n++;
      if (done8) seen = 1;
      else begin
        a8 = 8'($urandom); b8 = 8'($urandom); cin8 = ~cin8; sub8 = ~sub8;
        @(negedge clk);
      end
    end
    check({tag, "_done_seen"}, 64'(seen), 64'd1);
    check({tag, "_busy_cycles"}, 64'(busy_n), 64'd8);
    check({tag, "_overlap"}, 64'(overlap), 64'd0);
    want = (exp_q.size() > 0) ? exp_q.pop_front() : 9'h1xx;
    check({tag, "_result"}, {55'd0, cout8, sum8}, {55'd0, want});
    $display("txn %s a=%02h b=%02h cin=%0b sub=%0b -> sum=%02h cout=%0b", tag, ta, tb_,
             tcin, tsub, sum8, cout8);
    @(negedge clk);
    check({tag, "_done_1cyc"}, 64'(done8), 64'd0);
  endtask

  task automatic do1(input logic ta, input logic tb_, input string tag);
    int busy_n = 0;
    bit seen = 0;
    logic [1:0] want;
    a1 = ta; b1 = tb_; cin1 = 1'b0; sub1 = 1'b0; start1 = 1'b1;
    exp1_q.push_back({1'b0, ta} + {1'b0, tb_});
    @(negedge clk);
    start1 = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      if (busy1) busy_n++;
      if (done1) seen = 1;
      else begin
        a1 = ~a1; b1 = ~b1;
        @(negedge clk);
      end
    end
    check({tag, "_done_seen"}, 64'(seen), 64'd1);
    check({tag, "_busy_cycles"}, 64'(busy_n), 64'd1);
    want = (exp1_q.size() > 0) ? exp1_q.pop_front() : 2'bxx;
    check({tag, "_result"}, {62'd0, cout1, sum1}, {62'd0, want});
    $display("txn %s a=%0b b=%0b -> sum=%0b cout=%0b", tag, ta, tb_, sum1, cout1);
    @(negedge clk);
    check({tag, "_done_1cyc"}, 64'(done1), 64'd0);
  endtask

  initial begin
    int dones;
    logic [8:0] prev;
    logic [8:0] want;
    logic [7:0] ra, rb;
    logic rc, rs;

    rst = 1'b1;
    start8 = 0; sub8 = 0; cin8 = 0; a8 = 0; b8 = 0;
    start1 = 0; sub1 = 0; cin1 = 0; a1 = 0; b1 = 0;
    repeat (2) @(negedge clk);
    check("rst_busy8", 64'(busy8), 64'd0);
    check("rst_done8", 64'(done8), 64'd0);
    check("rst_sum8", {55'd0, cout8, sum8}, 64'd0);
    check("rst_w1", {61'd0, busy1, done1, cout1, sum1}, 64'd0);
    rst = 1'b0;
    @(negedge clk);

    do8(8'h0F, 8'h01, 1'b0, 1'b0, 9'h010, "add_0f_01");
    do8(8'hFF, 8'h01, 1'b0, 1'b0, 9'h100, "add_ff_01");
    do8(8'h7F, 8'h80, 1'b1, 1'b0, 9'h100, "add_7f_80_c");
    do8(8'h05, 8'h07, 1'b0, 1'b1, 9'h0FE, "sub_05_07");
    do8(8'h07, 8'h05, 1'b1, 1'b1, 9'h102, "sub_07_05");

    // Start pulses during RUN and FIN must be ignored.
    prev = {cout8, sum8};
    a8 = 8'h03; b8 = 8'h04; cin8 = 0; sub8 = 0; start8 = 1'b1;
    exp_q.push_back(9'h007);
    dones = 0;
    for (int i = 0; i < 13; i++) begin
      @(negedge clk);
      if (done8) dones++;
      if (i == 4) check("ign_hold_prev", {55'd0, cout8, sum8}, {55'd0, prev});
      if (i == 8) begin
        want = (exp_q.size() > 0) ? exp_q.pop_front() : 9'h1xx;
        check("ign_result", {55'd0, cout8, sum8}, {55'd0, want});
      end
      start8 = (i == 2 || i == 7 || i == 8);
      if (start8) begin a8 = 8'hAA; b8 = 8'h55; end
    end
    start8 = 1'b0;
    $display("txn ignore_start a=03 b=04 -> sum=%02h cout=%0b dones=%0d", sum8, cout8, dones);
    check("ign_single_done", 64'(dones), 64'd1);
    check("ign_no_restart", 64'(busy8), 64'd0);

    // Reset in the middle of a run aborts without a done pulse.
    a8 = 8'h12; b8 = 8'h34; start8 = 1'b1;
    dones = 0;
    for (int i = 0; i < 13; i++) begin
      @(negedge clk);
      start8 = 1'b0;
      if (done8) dones++;
      rst = (i == 3);
      if (i == 4) begin
        check("abort_busy", 64'(busy8), 64'd0);
        check("abort_sum", {55'd0, cout8, sum8}, 64'd0);
      end
    end
    $display("txn abort a=12 b=34 -> sum=%02h cout=%0b dones=%0d", sum8, cout8, dones);
    check("abort_no_done", 64'(dones), 64'd0);
    do8(8'h12, 8'h34, 1'b0, 1'b0, 9'h046, "after_abort");

    // Reset and start together: reset wins.
    rst = 1'b1; start8 = 1'b1; a8 = 8'h01; b8 = 8'h01;
    @(negedge clk);
    rst = 1'b0; start8 = 1'b0;
    check("rst_start_busy", 64'(busy8), 64'd0);
    check("rst_start_sum", {55'd0, cout8, sum8}, 64'd0);
    @(negedge clk);
    check("rst_start_idle", 64'(busy8), 64'd0);
    $display("txn rst_and_start -> busy=%0b sum=%02h", busy8, sum8);

    for (int k = 0; k < 6; k++) begin
      ra = 8'($urandom); rb = 8'($urandom);
      rc = 1'($urandom); rs = 1'($urandom);
      do8(ra, rb, rc, rs, model8(ra, rb, rc, rs), $sformatf("rand%0d", k));
    end

    do1(1'b0, 1'b0, "w1_00");
    do1(1'b0, 1'b1, "w1_01");
    do1(1'b1, 1'b0, "w1_10");
    do1(1'b1, 1'b1, "w1_11");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
